// File: rtl/irq_gateway.sv
// irq_gateway: per-source interrupt gateway in front of the PLIC.
// Synchronizes raw pins, detects level or rising-edge requests, holds each
// request pending until claimed, blocks the source until completion, and
// queues edges that arrive while blocked in a saturating per-source counter.
module irq_gateway #(
  parameter int unsigned NUM         = 4,
  parameter int unsigned IDW         = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CW          = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NUM-1:0]   src_irq,
  input  logic [NUM-1:0]   en_i,
  input  logic [NUM-1:0]   edge_i,
  input  logic             claim_valid,
  input  logic [IDW-1:0]   claim_id,
  input  logic             complete_valid,
  input  logic [IDW-1:0]   complete_id,
  output logic [NUM-1:0]   irq_o,
  output logic [NUM-1:0]   ovf_o,
  input  logic [NUM-1:0]   ovf_clr
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_CLAIMED = 2'd2
  } state_t;

  logic [NUM-1:0] r_sync [SYNC_STAGES];
  logic [NUM-1:0] r_prev;
  state_t         r_state     [NUM];
  state_t         w_state_nxt [NUM];
  logic [CW-1:0]  r_cnt       [NUM];
  logic [CW-1:0]  w_cnt_nxt   [NUM];
  logic [NUM-1:0] r_irq;
  logic [NUM-1:0] r_ovf;
  logic [NUM-1:0] w_irq_nxt;
  logic [NUM-1:0] w_ovf_set;
  logic [NUM-1:0] w_s;
  logic [NUM-1:0] w_edge_ev;
  logic [NUM-1:0] w_lvl_req;
  logic [NUM-1:0] w_claim_hit;
  logic [NUM-1:0] w_complete_hit;

  assign w_s       = r_sync[SYNC_STAGES-1];
  assign w_edge_ev = edge_i & w_s & ~r_prev;
  assign w_lvl_req = ~edge_i & w_s;

  assign irq_o = r_irq;
  assign ovf_o = r_ovf;

  // Input synchronizer chain plus one-cycle history for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        r_sync[k] <= '0;
      end
      r_prev <= '0;
    end else begin
      r_sync[0] <= src_irq;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
      r_prev <= w_s;
    end
  end

  // Per-source next state, edge-counter update and overflow detection.
  always_comb begin
    w_ovf_set      = '0;
    w_irq_nxt      = '0;
    w_claim_hit    = '0;
    w_complete_hit = '0;
    for (int i = 0; i < NUM; i++) begin
      w_state_nxt[i]    = r_state[i];
      w_cnt_nxt[i]      = r_cnt[i];
      w_claim_hit[i]    = claim_valid && (claim_id == IDW'(i + 1));
      w_complete_hit[i] = complete_valid && (complete_id == IDW'(i + 1));

      case (r_state[i])
        ST_IDLE: begin
          if (en_i[i] && (w_lvl_req[i] || w_edge_ev[i] || (r_cnt[i] != '0))) begin
            w_state_nxt[i] = ST_PENDING;
            // A queued edge is consumed only when no fresh request covers this exit.
            if (!w_lvl_req[i] && !w_edge_ev[i]) begin
              w_cnt_nxt[i] = r_cnt[i] - CW'(1);
            end
          end
        end
        ST_PENDING: begin
          if (w_claim_hit[i]) begin
            w_state_nxt[i] = ST_CLAIMED;
          end else if (!en_i[i]) begin
            w_state_nxt[i] = ST_IDLE;
          end
        end
        ST_CLAIMED: begin
          if (w_complete_hit[i]) begin
            w_state_nxt[i] = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt[i] = ST_IDLE;
        end
      endcase

      // Edges arriving while the source is busy are queued; disabled edges are dropped.
      if (w_edge_ev[i] && en_i[i] && (r_state[i] != ST_IDLE)) begin
        if (r_cnt[i] == CNT_MAX) begin
          w_ovf_set[i] = 1'b1;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CW'(1);
        end
      end

      if (!edge_i[i]) begin
        w_cnt_nxt[i] = '0;
      end

      w_irq_nxt[i] = (w_state_nxt[i] == ST_PENDING);
    end
  end

  // FSM state, counters, request outputs and sticky overflow flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM; i++) begin
        r_state[i] <= ST_IDLE;
        r_cnt[i]   <= '0;
      end
      r_irq <= '0;
      r_ovf <= '0;
    end else begin
      for (int i = 0; i < NUM; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
      r_irq <= w_irq_nxt;
      r_ovf <= w_ovf_set | (r_ovf & ~ovf_clr);
    end
  end

endmodule

// File: tb/tb_irq_gateway.sv
// Testbench for irq_gateway: directed scenarios followed by random traffic,
// all checked cycle by cycle against a behavioural model via a scoreboard.
module tb_irq_gateway;

  localparam int NUM  = 4;
  localparam int IDW  = 3;
  localparam int SYNC = 2;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic [NUM-1:0] irq;
    logic [NUM-1:0] ovf;
  } exp_t;

  logic           clk;
  logic           rst;
  logic [NUM-1:0] src_irq;
  logic [NUM-1:0] en_i;
  logic [NUM-1:0] edge_i;
  logic           claim_valid;
  logic [IDW-1:0] claim_id;
  logic           complete_valid;
  logic [IDW-1:0] complete_id;
  logic [NUM-1:0] irq_o;
  logic [NUM-1:0] ovf_o;
  logic [NUM-1:0] ovf_clr;

  int checks;
  int failures;
  int cyc;

  exp_t exp_q[$];

  // Reference model: request flags, queued edge counts, pin history.
  bit             m_pend [NUM];
  bit             m_clm  [NUM];
  int             m_cnt  [NUM];
  logic [NUM-1:0] m_ovf;
  logic [NUM-1:0] m_sh   [SYNC];
  logic [NUM-1:0] m_prev;

  irq_gateway #(.NUM(NUM), .IDW(IDW), .SYNC_STAGES(SYNC), .CW(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .src_irq        (src_irq),
    .en_i           (en_i),
    .edge_i         (edge_i),
    .claim_valid    (claim_valid),
    .claim_id       (claim_id),
    .complete_valid (complete_valid),
    .complete_id    (complete_id),
    .irq_o          (irq_o),
    .ovf_o          (ovf_o),
    .ovf_clr        (ovf_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    logic [NUM-1:0] s;
    logic [NUM-1:0] p;
    exp_t e;
    bit ev, lvl, cl, cp, busy, ovs;
    if (rst) begin
      for (int i = 0; i < NUM; i++) begin
        m_pend[i] = 1'b0;
        m_clm[i]  = 1'b0;
        m_cnt[i]  = 0;
      end
      m_ovf  = '0;
      m_prev = '0;
      for (int k = 0; k < SYNC; k++) m_sh[k] = '0;
    end else begin
      s = m_sh[SYNC-1];
      p = m_prev;
      for (int i = 0; i < NUM; i++) begin
        ev   = edge_i[i] && s[i] && !p[i];
        lvl  = !edge_i[i] && s[i];
        cl   = claim_valid && (int'(claim_id) == i + 1);
        cp   = complete_valid && (int'(complete_id) == i + 1);
        busy = m_pend[i] || m_clm[i];
        ovs  = 1'b0;
        if (m_clm[i]) begin
          if (cp) m_clm[i] = 1'b0;
        end else if (m_pend[i]) begin
          if (cl) begin
            m_pend[i] = 1'b0;
            m_clm[i]  = 1'b1;
          end else if (!en_i[i]) begin
            m_pend[i] = 1'b0;
          end
        end else if (en_i[i]) begin
          if (lvl || ev) begin
            m_pend[i] = 1'b1;
          end else if (m_cnt[i] > 0) begin
            m_pend[i] = 1'b1;
            m_cnt[i]  = m_cnt[i] - 1;
          end
        end
        if (busy && ev && en_i[i]) begin
          if (m_cnt[i] == CMAX) ovs = 1'b1;
          else m_cnt[i] = m_cnt[i] + 1;
        end
        if (!edge_i[i]) m_cnt[i] = 0;
        m_ovf[i] = ovs | (m_ovf[i] & ~ovf_clr[i]);
      end
      m_prev = s;
      for (int k = SYNC - 1; k > 0; k--) m_sh[k] = m_sh[k-1];
      m_sh[0] = src_irq;
    end
    for (int i = 0; i < NUM; i++) e.irq[i] = m_pend[i];
    e.ovf = m_ovf;
    exp_q.push_back(e);
  endtask

  // One clock: model follows the edge, inputs change again at the falling edge.
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic chk(input string nm, input logic [NUM-1:0] act, input logic [NUM-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic do_claim(input int id);
    claim_valid = 1'b1;
    claim_id    = IDW'(id);
    step();
    claim_valid = 1'b0;
    claim_id    = '0;
  endtask

  task automatic do_complete(input int id);
    complete_valid = 1'b1;
    complete_id    = IDW'(id);
    step();
    complete_valid = 1'b0;
    complete_id    = '0;
  endtask

  task automatic pulse(input int i);
    src_irq[i] = 1'b1;
    steps(2);
    src_irq[i] = 1'b0;
    steps(2);
  endtask

  // Scoreboard monitor: compares every output sample against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (irq_o !== e.irq || ovf_o !== e.ovf) begin
          failures++;
          $display("FAIL scoreboard: irq_o=%b ovf_o=%b expected irq=%b ovf=%b (cycle %0d)",
                   irq_o, ovf_o, e.irq, e.ovf, cyc);
        end
      end
    end
  end

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    for (int i = 0; i < NUM; i++) begin
      m_pend[i] = 1'b0;
      m_clm[i]  = 1'b0;
      m_cnt[i]  = 0;
    end
    m_ovf  = '0;
    m_prev = '0;
    for (int k = 0; k < SYNC; k++) m_sh[k] = '0;

    rst            = 1'b1;
    src_irq        = '0;
    en_i           = 4'b1111;
    edge_i         = 4'b0110;
    claim_valid    = 1'b0;
    claim_id       = '0;
    complete_valid = 1'b0;
    complete_id    = '0;
    ovf_clr        = '0;

    // Reset state
    steps(3);
    chk("reset_irq", irq_o, 4'b0000);
    chk("reset_ovf", ovf_o, 4'b0000);
    rst = 1'b0;
    steps(2);

    // Level pend, claim, re-pend after completion with pin still high
    src_irq[0] = 1'b1;
    steps(2);
    chk("level_not_yet", irq_o, 4'b0000);
    step();
    chk("level_pend", irq_o, 4'b0001);
    do_claim(1);
    chk("level_claimed", irq_o, 4'b0000);
    steps(2);
    do_complete(1);
    chk("level_completed", irq_o, 4'b0000);
    step();
    chk("level_repend", irq_o, 4'b0001);
    src_irq[0] = 1'b0;
    do_claim(1);
    do_complete(1);
    steps(4);
    chk("level_quiet", irq_o, 4'b0000);

    // Edge queueing on source 2
    pulse(2);
    chk("edge_pend", irq_o, 4'b0100);
    do_claim(3);
    for (int k = 0; k < 3; k++) pulse(2);
    chk("edge_blocked", irq_o, 4'b0000);
    for (int r = 0; r < 3; r++) begin
      do_complete(3);
      step();
      chk("edge_round_repend", irq_o, 4'b0100);
      do_claim(3);
    end
    do_complete(3);
    steps(3);
    chk("edge_drained", irq_o, 4'b0000);

    // Invalid IDs while source 1 is pending
    pulse(1);
    chk("inv_pend", irq_o, 4'b0010);
    do_claim(0);
    chk("inv_claim0", irq_o, 4'b0010);
    do_claim(5);
    chk("inv_claim5", irq_o, 4'b0010);
    do_complete(2);
    chk("inv_complete2", irq_o, 4'b0010);

    // Simultaneous claim of source 0 and completion of source 2
    src_irq[0] = 1'b1;
    steps(3);
    pulse(2);
    do_claim(3);
    chk("sim_before", irq_o, 4'b0011);
    claim_valid    = 1'b1;
    claim_id       = 3'd1;
    complete_valid = 1'b1;
    complete_id    = 3'd3;
    step();
    claim_valid    = 1'b0;
    complete_valid = 1'b0;
    chk("sim_after", irq_o, 4'b0010);
    pulse(2);
    chk("sim_src2_idle", irq_o, 4'b0110);
    src_irq[0] = 1'b0;
    do_claim(3);
    do_complete(3);
    steps(2);
    do_complete(1);
    steps(3);
    chk("sim_cleanup", irq_o, 4'b0010);

    // Overflow on source 1 while claimed
    do_claim(2);
    for (int k = 0; k < 9; k++) pulse(1);
    chk("ovf_set", ovf_o, 4'b0010);
    ovf_clr[1] = 1'b1;
    step();
    ovf_clr[1] = 1'b0;
    chk("ovf_cleared", ovf_o, 4'b0000);
    pulse(1);
    chk("ovf_reset_again", ovf_o, 4'b0010);

    // Reset mid-operation with source 0 pending and source 1 claimed with queued edges
    src_irq[0] = 1'b1;
    steps(3);
    chk("mid_pend", irq_o, 4'b0001);
    rst = 1'b1;
    #1;
    chk("async_rst_irq", irq_o, 4'b0000);
    chk("async_rst_ovf", ovf_o, 4'b0000);
    step();
    src_irq[0] = 1'b0;
    steps(2);
    rst = 1'b0;
    steps(10);
    chk("post_rst_irq", irq_o, 4'b0000);
    chk("post_rst_ovf", ovf_o, 4'b0000);

    // Random traffic
    edge_i = NUM'($urandom);
    for (int n = 0; n < 1500; n++) begin
      if (n % 200 == 0) begin
        for (int i = 0; i < NUM; i++) en_i[i] = ($urandom_range(0, 4) != 0);
      end
      for (int i = 0; i < NUM; i++) begin
        if ($urandom_range(0, 5) == 0) src_irq[i] = ~src_irq[i];
        ovf_clr[i] = ($urandom_range(0, 7) == 0);
      end
      claim_valid    = ($urandom_range(0, 2) == 0);
      claim_id       = IDW'($urandom_range(0, 7));
      complete_valid = ($urandom_range(0, 2) == 0);
      complete_id    = IDW'($urandom_range(0, 7));
      rst            = (n >= 750 && n < 752);
      step();
    end
    claim_valid    = 1'b0;
    complete_valid = 1'b0;
    ovf_clr        = '0;
    steps(2);
    #2;

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
